// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch reset vector, bubble encoding and fetch FSM states.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage: a fresh redirect beats a pending target, which beats PC+4.
module if_next_pc (
  input  logic [31:0] pc,
  input  logic        pend_vld,
  input  logic [31:0] pend_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] redirect_tgt,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  // Instruction addresses are word aligned, so the low two target bits are forced to zero.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4     = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (redirect) begin
      next_pc = redirect_tgt;
    end else if (pend_vld) begin
      next_pc = pend_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, keeps one request outstanding to instruction memory,
// and holds the fetched word for the F/D register, honouring delay-slot redirects from D.
//
// state       | meaning
// FETCH_ISSUE | imem_req driven for the current PC (first cycle after reset only arms the strobe)
// FETCH_WAIT  | request in flight, waiting for imem_rvalid
// FETCH_HOLD  | instruction presented on InstrF, waiting for EN to consume it
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PC_4F,
  output logic        ValidF
);

  import mips_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic         pend_vld;
  logic         req_q;
  logic         valid_q;
  logic [31:0]  instr_q;

  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_tgt;
  logic         consume;

  if_next_pc u_next_pc (
    .pc           (pc),
    .pend_vld     (pend_vld),
    .pend_pc      (pend_pc),
    .redirect     (Redirect),
    .redirect_pc  (RedirectPC),
    .redirect_tgt (redirect_tgt),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  assign consume = (state == FETCH_HOLD) && EN;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH_ISSUE;
      pc       <= RESET_PC;
      pend_vld <= 1'b0;
      pend_pc  <= 32'h0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
    end else begin
      case (state)
        FETCH_ISSUE: begin
          // req_q low here only right after reset; it rises for exactly one cycle per request.
          if (req_q) begin
            req_q <= 1'b0;
            state <= FETCH_WAIT;
          end else begin
            req_q <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state   <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (EN) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            pc      <= next_pc;
            req_q   <= 1'b1;
            state   <= FETCH_ISSUE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= FETCH_ISSUE;
        end
      endcase

      // A redirect that coincides with consumption is folded straight into next_pc.
      if (consume) begin
        pend_vld <= 1'b0;
      end else if (Redirect) begin
        pend_vld <= 1'b1;
        pend_pc  <= redirect_tgt;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign InstrF    = instr_q;
  assign PC_4F     = pc_plus4;
  assign ValidF    = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a slot-level reference model predicts every cycle's outputs.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        EN;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PC_4F;
  logic        ValidF;

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .EN          (EN),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PC_4F       (PC_4F),
    .ValidF      (ValidF)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: where the current slot lives and what has been promised about the next one.
  logic        m_boot;
  logic        m_req_now;
  logic        m_inflight;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  logic        m_pend;
  logic [31:0] m_pend_pc;

  int wait_cnt = 0;
  int lat_max  = 4;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot     = 1'b1;
    m_req_now  = 1'b0;
    m_inflight = 1'b0;
    m_valid    = 1'b0;
    m_instr    = NOP;
    m_addr     = RST_PC;
    m_pend     = 1'b0;
    m_pend_pc  = 32'h0;
  endtask

  task automatic check_outputs();
    check_eq("imem_req", {31'h0, imem_req}, {31'h0, m_req_now});
    check_eq("ValidF", {31'h0, ValidF}, {31'h0, m_valid});
    check_eq("InstrF", InstrF, m_valid ? m_instr : NOP);
    if (m_req_now || m_inflight) check_eq("imem_addr", imem_addr, m_addr);
    if (m_valid) check_eq("PC_4F", PC_4F, m_addr + 32'd4);
  endtask

  // One clock cycle: memory model reacts, inputs applied, edge, model advanced, outputs checked.
  task automatic drive_cycle(input logic en_v, input logic red_v, input logic [31:0] rpc_v);
    logic        rv;
    logic [31:0] rd;
    logic [31:0] tgt;
    logic [29:0] hi;
    logic        consume;
    if (imem_req) begin
      wait_cnt = $urandom_range(1, lat_max);
      rv = ($urandom_range(0, 3) == 0);
    end else if (wait_cnt > 0) begin
      wait_cnt--;
      rv = (wait_cnt == 0);
    end else begin
      rv = ($urandom_range(0, 3) == 0);
    end
    rd = $urandom;
    EN = en_v;
    Redirect = red_v;
    RedirectPC = rpc_v;
    imem_rvalid = rv;
    imem_rdata = rd;
    @(posedge clk);
    hi = rpc_v[31:2];
    tgt = {hi, 2'b00};
    consume = m_valid && en_v;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req_now = 1'b1;
    end else if (m_req_now) begin
      m_req_now = 1'b0;
      m_inflight = 1'b1;
    end else if (m_inflight) begin
      if (rv) begin
        m_inflight = 1'b0;
        m_valid = 1'b1;
        m_instr = rd;
      end
    end else if (consume) begin
      m_valid = 1'b0;
      m_addr = red_v ? tgt : (m_pend ? m_pend_pc : m_addr + 32'd4);
      m_pend = 1'b0;
      m_req_now = 1'b1;
    end
    if (red_v && !consume) begin
      m_pend = 1'b1;
      m_pend_pc = tgt;
    end
    #1;
    check_outputs();
  endtask

  task automatic run_until_valid(input string tag);
    for (int i = 0; i < 20 && !m_valid; i++) drive_cycle(1'b0, 1'b0, 32'h0);
    check_eq(tag, {31'h0, ValidF}, 32'h1);
  endtask

  task automatic run_until_inflight(input string tag);
    for (int i = 0; i < 20 && !m_inflight; i++) drive_cycle(1'b1, 1'b0, 32'h0);
    check_eq(tag, {31'h0, imem_req | (m_inflight ? 1'b0 : 1'b1)}, 32'h0);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = $urandom;
      1: t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      2: t = 32'h0000_3400;
      default: t = 32'h0000_3103;
    endcase
    return t;
  endfunction

  initial begin
    reset = 1'b0;
    EN = 1'b0;
    Redirect = 1'b0;
    RedirectPC = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check_eq("reset_pc_4f", PC_4F, RST_PC + 32'd4);
    reset = 1'b1;

    // Basic flow with a one-cycle memory: requests 3 cycles apart.
    lat_max = 1;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 32'h0);
    lat_max = 4;

    // Stall in HOLD for five cycles, then release.
    run_until_valid("reach_hold_stall");
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 32'h0);

    // Redirect while the delay slot is in flight.
    run_until_inflight("reach_wait_redirect");
    drive_cycle(1'b1, 1'b1, 32'h0000_3400);
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 32'h0);

    // Redirect on the consuming edge, unaligned target.
    run_until_valid("reach_hold_redirect");
    drive_cycle(1'b1, 1'b1, 32'h0000_3103);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 32'h0);

    // Redirect during a stall, applied at the eventual consumption.
    run_until_valid("reach_hold_stalled_redirect");
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    drive_cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic en_v;
      logic red_v;
      en_v = ($urandom_range(0, 99) < 55);
      red_v = ($urandom_range(0, 9) == 0);
      drive_cycle(en_v, red_v, pick_target());
    end

    // Asynchronous reset in the middle of a request.
    run_until_inflight("reach_wait_reset");
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_validf", {31'h0, ValidF}, 32'h0);
    check_eq("async_rst_req", {31'h0, imem_req}, 32'h0);
    check_eq("async_rst_instr", InstrF, NOP);
    model_reset();
    wait_cnt = 0;
    imem_rvalid = 1'b0;
    Redirect = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, pick_target());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
